// File: rtl/uart_tx_pkg.sv
// Shared state encoding, parity-type constants and default payload width
// for the UART transmit controller.
package uart_tx_pkg;

    localparam int DATA_W_DEF = 8;

    typedef logic [2:0] tx_state_t;

    localparam tx_state_t ST_IDLE   = 3'd0;
    localparam tx_state_t ST_START  = 3'd1;
    localparam tx_state_t ST_DATA   = 3'd2;
    localparam tx_state_t ST_PARITY = 3'd3;
    localparam tx_state_t ST_STOP   = 3'd4;

    localparam logic EVEN_PAR = 1'b0;
    localparam logic ODD_PAR  = 1'b1;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Request/serial-line bundle between a byte source and uart_tx_ctrl.
interface uart_tx_ctrl_if
    import uart_tx_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic [DATA_W-1:0] P_DATA;
    logic              DATA_VALID;
    logic              PAR_EN;
    logic              PAR_TYP;
    logic              TX_OUT;
    logic              BUSY;
    logic              FRAME_DONE;

    modport master (
        output P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
        input  TX_OUT, BUSY, FRAME_DONE
    );

    modport slave (
        input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
        output TX_OUT, BUSY, FRAME_DONE
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// Payload shift register and bit counter; presents the current and next
// LSB so the controller can register the serial line one cycle ahead.
module uart_tx_serializer #(
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              enable,
    output logic              bit_cur,
    output logic              bit_nxt,
    output logic              done
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0] sh_q;
    logic [DATA_W-1:0] sh_nxt;
    logic [CNT_W-1:0]  cnt_q;

    assign sh_nxt = sh_q >> 1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else if (load) begin
            sh_q  <= load_data;
            cnt_q <= '0;
        end else if (enable) begin
            // counter returns to zero on the cycle the controller leaves DATA
            if (done) begin
                cnt_q <= '0;
            end else begin
                sh_q  <= sh_nxt;
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bit_cur = sh_q[0];
    assign bit_nxt = sh_nxt[0];
    assign done    = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART frame transmitter: start bit, LSB-first payload, optional parity, stop bit.
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
//
// state     | meaning
// ----------+-------------------------------------------------------
// ST_IDLE   | line at IDLE_LVL, waiting for DATA_VALID
// ST_START  | start bit (0)
// ST_DATA   | payload bits, LSB first, one per cycle
// ST_PARITY | parity over the captured byte (parity build only)
// ST_STOP   | stop bit at IDLE_LVL, FRAME_DONE pulses
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int   DATA_W   = DATA_W_DEF,
    parameter logic IDLE_LVL = 1'b1
) (
    input  logic           CLK,
    input  logic           RST,
    uart_tx_ctrl_if.slave  bus
);
    tx_state_t state_q, state_d;
    logic      tx_q, tx_d;
    logic      busy_q, busy_d;
    logic      done_q, done_d;
    logic      accept;
    logic      ser_en, ser_bit, ser_bit_nxt, ser_done;

    assign accept = (state_q == ST_IDLE) && bus.DATA_VALID;

    uart_tx_serializer #(
        .DATA_W (DATA_W)
    ) u_ser (
        .CLK       (CLK),
        .RST       (RST),
        .load      (accept),
        .load_data (bus.P_DATA),
        .enable    (ser_en),
        .bit_cur   (ser_bit),
        .bit_nxt   (ser_bit_nxt),
        .done      (ser_done)
    );

`ifdef UART_TX_PARITY_EN
    logic [DATA_W-1:0] data_q;
    logic              par_en_q;
    logic              par_typ_q;
    logic              par_bit;

    always_ff @(posedge CLK) begin
        if (RST) begin
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
        end else if (accept) begin
            data_q    <= bus.P_DATA;
            par_en_q  <= bus.PAR_EN;
            par_typ_q <= bus.PAR_TYP;
        end
    end

    assign par_bit = (par_typ_q == EVEN_PAR) ? ^data_q : ~^data_q;
`else
    logic unused_par_cfg;
    assign unused_par_cfg = bus.PAR_EN ^ bus.PAR_TYP;
`endif

    // outputs are registered from the next state so TX_OUT and BUSY stay aligned
    always_comb begin
        state_d = state_q;
        tx_d    = IDLE_LVL;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        ser_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_START;
                    tx_d    = 1'b0;
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_START: begin
                state_d = ST_DATA;
                tx_d    = ser_bit;
            end
            ST_DATA: begin
                ser_en = 1'b1;
                if (!ser_done) begin
                    tx_d = ser_bit_nxt;
                end
`ifdef UART_TX_PARITY_EN
                else if (par_en_q) begin
                    state_d = ST_PARITY;
                    tx_d    = par_bit;
                end
`endif
                else begin
                    state_d = ST_STOP;
                    done_d  = 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                state_d = ST_STOP;
                done_d  = 1'b1;
            end
`endif
            ST_STOP: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            tx_q    <= IDLE_LVL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.TX_OUT     = tx_q;
    assign bus.BUSY       = busy_q;
    assign bus.FRAME_DONE = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: directed frames plus randomized
// traffic compared against a bit-list frame model.
module tb_uart_tx_ctrl;

    localparam int DW = 8;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_BUILD = 1'b1;
`else
    localparam bit PAR_BUILD = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   exp_q[$];

    uart_tx_ctrl_if #(.DATA_W(DW)) bus();

    uart_tx_ctrl #(
        .DATA_W   (DW),
        .IDLE_LVL (1'b1)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line levels for one frame: start, payload LSB first, parity, stop.
    function automatic void build_frame(input logic [DW-1:0] d, input bit pe, input bit pt);
        int ones;
        ones = 0;
        exp_q.delete();
        exp_q.push_back(1'b0);
        for (int b = 0; b < DW; b++) begin
            exp_q.push_back(d[b]);
            ones += int'(d[b]);
        end
        if (PAR_BUILD && pe)
            exp_q.push_back(pt ? (ones % 2 == 0) : (ones % 2 == 1));
        exp_q.push_back(1'b1);
    endfunction

    task automatic scramble(input bit hold);
        bus.P_DATA     = DW'($urandom);
        bus.PAR_EN     = 1'($urandom);
        bus.PAR_TYP    = 1'($urandom);
        bus.DATA_VALID = hold ? 1'b1 : 1'($urandom);
    endtask

    task automatic idle_cycle(input string tag);
        @(negedge CLK);
        chk({tag, "/idle_tx"},   bus.TX_OUT, 1);
        chk({tag, "/idle_busy"}, bus.BUSY, 0);
        chk({tag, "/idle_fd"},   bus.FRAME_DONE, 0);
        @(posedge CLK); #1;
    endtask

    // Entered just after a rising edge with the DUT in IDLE; returns just after
    // the edge that ends STOP, leaving DATA_VALID=hold.
    task automatic run_frame(input string tag, input logic [DW-1:0] d,
                             input bit pe, input bit pt, input bit hold);
        int len;
        build_frame(d, pe, pt);
        len = exp_q.size();
        bus.P_DATA     = d;
        bus.PAR_EN     = pe;
        bus.PAR_TYP    = pt;
        bus.DATA_VALID = 1'b1;
        @(negedge CLK);
        chk({tag, "/pre_busy"}, bus.BUSY, 0);
        chk({tag, "/pre_tx"},   bus.TX_OUT, 1);
        @(posedge CLK); #1;
        scramble(hold);
        for (int i = 0; i < len; i++) begin
            @(negedge CLK);
            chk($sformatf("%s/tx%0d", tag, i),   bus.TX_OUT, exp_q[i]);
            chk($sformatf("%s/busy%0d", tag, i), bus.BUSY, 1);
            chk($sformatf("%s/fd%0d", tag, i),   bus.FRAME_DONE, (i == len - 1));
            @(posedge CLK); #1;
            if (i < len - 1) scramble(hold);
        end
        bus.DATA_VALID = hold;
    endtask

    task automatic reset_abort();
        build_frame(8'h0F, 1'b0, 1'b0);
        bus.P_DATA     = 8'h0F;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        bus.DATA_VALID = 1'b1;
        @(posedge CLK); #1;
        scramble(1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk($sformatf("abort/tx%0d", i), bus.TX_OUT, exp_q[i]);
            @(posedge CLK); #1;
            scramble(1'b0);
        end
        RST = 1'b1;
        @(negedge CLK);
        chk("abort/bit4_tx", bus.TX_OUT, exp_q[5]);
        chk("abort/bit4_busy", bus.BUSY, 1);
        @(posedge CLK); #1;
        RST = 1'b0;
        bus.DATA_VALID = 1'b0;
        @(negedge CLK);
        chk("abort/post_tx",   bus.TX_OUT, 1);
        chk("abort/post_busy", bus.BUSY, 0);
        chk("abort/post_fd",   bus.FRAME_DONE, 0);
        @(posedge CLK); #1;
        idle_cycle("abort_idle");
    endtask

    initial begin
        bit prev_hold;
        bit hold;
        bus.P_DATA     = 8'h5A;
        bus.DATA_VALID = 1'b1;
        bus.PAR_EN     = 1'b1;
        bus.PAR_TYP    = 1'b0;
        RST            = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        @(negedge CLK);
        chk("reset/tx",   bus.TX_OUT, 1);
        chk("reset/busy", bus.BUSY, 0);
        chk("reset/fd",   bus.FRAME_DONE, 0);
        @(posedge CLK); #1;
        RST = 1'b0;

        run_frame("a5_even",  8'hA5, 1'b1, 1'b0, 1'b0);
        run_frame("a5_odd",   8'hA5, 1'b1, 1'b1, 1'b0);
        run_frame("01_even",  8'h01, 1'b1, 1'b0, 1'b0);
        run_frame("ff_nopar", 8'hFF, 1'b0, 1'b0, 1'b0);
        idle_cycle("gap0");

        for (int k = 0; k < 4; k++)
            run_frame($sformatf("b2b%0d", k), DW'($urandom), 1'($urandom), 1'($urandom), (k < 3));
        repeat (3) idle_cycle("gap1");

        reset_abort();
        run_frame("post_rst", 8'h96, 1'b1, 1'b1, 1'b0);

        prev_hold = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (!prev_hold) begin
                bus.DATA_VALID = 1'b0;
                repeat ($urandom_range(0, 2)) idle_cycle("rgap");
            end
            hold = 1'($urandom);
            run_frame($sformatf("rnd%0d", k), DW'($urandom), 1'($urandom), 1'($urandom), hold);
            prev_hold = hold;
        end
        bus.DATA_VALID = 1'b0;
        idle_cycle("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have ports: CLK  in  1  sole clock, rising edge; RST  in  1  synchronous reset, active-high.
REQ-002 SHALL have ports: P_DATA  in  8  byte to send; DATA_VALID  in  1  request strobe; PAR_EN  in  1  parity bit enable; PAR_TYP  in  1  0=even, 1=odd.
REQ-003 SHALL have ports: TX_OUT  out  1  serial line; BUSY  out  1  frame in progress; FRAME_DONE  out  1  one-cycle end-of-frame pulse.
REQ-004 SHALL have parameters: DATA_W, default 8, payload width; IDLE_LVL, default 1'b1, line level when idle and for the stop bit.

Function
REQ-005 SHALL implement the FSM states IDLE, START, DATA, PARITY, STOP, one bit per CLK cycle.
REQ-006 SHALL accept a request only in IDLE with DATA_VALID=1, capturing P_DATA, PAR_EN and PAR_TYP into internal registers on that edge.
REQ-007 SHALL ignore DATA_VALID in every non-IDLE state, with no queuing and no effect on the frame in flight.
REQ-008 SHALL drive TX_OUT=0 in START on the cycle after acceptance (latency 1).
REQ-009 SHALL shift DATA LSB first for exactly DATA_W cycles, using a bit counter 0..DATA_W-1 that clears on leaving DATA.
REQ-010 SHALL go DATA->PARITY when captured PAR_EN=1, else DATA->STOP.
REQ-011 SHALL drive the PARITY bit as XOR-reduce(data) for even and XNOR-reduce(data) for odd, computed from the captured byte.
REQ-012 SHALL drive TX_OUT=IDLE_LVL in STOP and IDLE.
REQ-013 SHALL pulse FRAME_DONE=1 for the single STOP cycle, then return to IDLE.
REQ-014 SHALL assert BUSY in START, DATA, PARITY and STOP, and deassert it in IDLE; BUSY is registered and aligned with TX_OUT.
REQ-015 SHALL give a frame length of DATA_W+3 cycles with parity and DATA_W+2 without; a new request is accepted no earlier than the IDLE cycle after STOP.
REQ-016 SHALL ensure that changes to P_DATA, PAR_EN or PAR_TYP mid-frame do not alter the frame in flight.

Reset
REQ-017 SHALL, while RST=1 at a CLK edge, force: state=IDLE, TX_OUT=IDLE_LVL, BUSY=0, FRAME_DONE=0, bit counter=0, captured registers=0.
REQ-018 SHALL abort a frame in flight immediately on reset, with no stop bit emitted; the line returns to IDLE_LVL on that edge.
REQ-019 SHALL leave DATA_VALID ignored in the reset cycle; the first accept is possible on the first edge with RST=0.

Configuration
REQ-020 SHALL, with macro UART_TX_PARITY_EN defined, implement the PARITY state and honour PAR_EN/PAR_TYP.
REQ-021 SHALL, without UART_TX_PARITY_EN, remove the PARITY state and parity logic, leave PAR_EN/PAR_TYP present but unused, and make every frame DATA_W+2 cycles.

Structure
REQ-022 SHALL place the state encoding (IDLE..STOP), the EVEN_PAR/ODD_PAR constants and the default DATA_W in shared package uart_tx_pkg.
REQ-023 SHALL instantiate one sub-module, uart_tx_serializer, holding the shift register and bit counter with load/enable/done handshake to the FSM; the parity computation stays in the FSM.

Verification
REQ-024 SHALL verify: P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 -> TX_OUT 0,1,0,1,0,0,1,0,1,0,1 over 11 cycles, BUSY=1 for those 11 cycles, FRAME_DONE on cycle 11.
REQ-025 SHALL verify: P_DATA=0xA5, PAR_TYP=1 -> parity bit=1; P_DATA=0x01, PAR_TYP=0 -> parity bit=1.
REQ-026 SHALL verify: P_DATA=0xFF, PAR_EN=0 -> TX_OUT 0, eight 1s, 1 over 10 cycles; no PARITY state visited.
REQ-027 SHALL verify: DATA_VALID held high continuously with P_DATA changing every cycle -> each frame carries the byte captured at its IDLE accept, with exactly one IDLE cycle between frames.
REQ-028 SHALL verify: RST=1 pulsed during DATA bit 4 -> next cycle TX_OUT=1, BUSY=0, FRAME_DONE=0; a following request produces a clean full frame.
REQ-029 SHALL verify: build without UART_TX_PARITY_EN, PAR_EN=1 -> 10-cycle frame with no parity bit.
